// File: rtl/sauto_turn_sequencer_if.sv
// Handshake bundle for the semi-auto turn sequencer:
// requests and sensor level in, motor commands and status out.
interface sauto_turn_sequencer_if;
    logic start;
    logic dir_left;
    logic dir_right;
    logic abort;
    logic front_detector;
    logic turn_left;
    logic turn_right;
    logic move_forward;
    logic busy;
    logic finish;
    logic blocked;
    logic dir_error;

    modport master (
        output start, dir_left, dir_right, abort, front_detector,
        input  turn_left, turn_right, move_forward,
        input  busy, finish, blocked, dir_error
    );

    modport slave (
        input  start, dir_left, dir_right, abort, front_detector,
        output turn_left, turn_right, move_forward,
        output busy, finish, blocked, dir_error
    );
endinterface

// File: rtl/sauto_turn_sequencer.sv
// Timed turn executor: turn, all-stop settle, forward clear, finish pulse.
// All motor commands are registered and derived from the next state.
module sauto_turn_sequencer #(
    parameter int CLK_PER_MS = 100000,
    parameter int TURN_MS    = 900,
    parameter int SETTLE_MS  = 100,
    parameter int CLEAR_MS   = 400
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    sauto_turn_sequencer_if.slave io
);
    localparam int MS_MAX = (TURN_MS > SETTLE_MS)
                          ? ((TURN_MS > CLEAR_MS) ? TURN_MS : CLEAR_MS)
                          : ((SETTLE_MS > CLEAR_MS) ? SETTLE_MS : CLEAR_MS);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int MW = (MS_MAX > 0) ? $clog2(MS_MAX + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, TURN, SETTLE, CLEAR, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [MW-1:0] ms_q, ms_d;
    logic          left_q, left_d;
    logic          blocked_q, blocked_d;
    logic          dir_error_q, dir_error_d;
    logic          turn_left_q, turn_left_d;
    logic          turn_right_q, turn_right_d;
    logic          move_forward_q, move_forward_d;
    logic          busy_q, busy_d;
    logic          finish_q, finish_d;
    logic          tick;

    assign tick = (presc_q == PW'(CLK_PER_MS - 1));

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        blocked_d   = blocked_q;
        dir_error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (io.start && !io.abort) begin
                    if (io.dir_left ^ io.dir_right) begin
                        state_d   = TURN;
                        left_d    = io.dir_left;
                        blocked_d = 1'b0;
                    end else begin
                        dir_error_d = 1'b1;
                    end
                end
            end
            TURN: begin
                if (tick && ms_q == MW'(TURN_MS - 1))
                    state_d = (SETTLE_MS == 0) ? CLEAR : SETTLE;
            end
            SETTLE: begin
                if (tick && ms_q == MW'(SETTLE_MS - 1))
                    state_d = CLEAR;
            end
            CLEAR: begin
                if (io.front_detector) begin
                    state_d   = DONE;
                    blocked_d = 1'b1;
                end else if (tick && ms_q == MW'(CLEAR_MS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // abort outranks both the ms tick and the obstacle sensor
        if (io.abort && state_q != IDLE) begin
            state_d   = IDLE;
            blocked_d = blocked_q;
        end

        if (state_d != state_q || state_q == IDLE) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (tick) begin
            presc_d = '0;
            ms_d    = ms_q + MW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
            ms_d    = ms_q;
        end

        turn_left_d    = (state_d == TURN) && left_d;
        turn_right_d   = (state_d == TURN) && !left_d;
        move_forward_d = (state_d == CLEAR);
        busy_d         = (state_d != IDLE);
        finish_d       = (state_d == DONE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            ms_q           <= '0;
            left_q         <= 1'b0;
            blocked_q      <= 1'b0;
            dir_error_q    <= 1'b0;
            turn_left_q    <= 1'b0;
            turn_right_q   <= 1'b0;
            move_forward_q <= 1'b0;
            busy_q         <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            ms_q           <= ms_d;
            left_q         <= left_d;
            blocked_q      <= blocked_d;
            dir_error_q    <= dir_error_d;
            turn_left_q    <= turn_left_d;
            turn_right_q   <= turn_right_d;
            move_forward_q <= move_forward_d;
            busy_q         <= busy_d;
            finish_q       <= finish_d;
        end
    end

    assign io.turn_left    = turn_left_q;
    assign io.turn_right   = turn_right_q;
    assign io.move_forward = move_forward_q;
    assign io.busy         = busy_q;
    assign io.finish       = finish_q;
    assign io.blocked      = blocked_q;
    assign io.dir_error    = dir_error_q;
endmodule

// File: tb/tb_sauto_turn_sequencer.sv
// Directed bench for sauto_turn_sequencer with shortened timing:
// CLK_PER_MS=4, TURN_MS=3, SETTLE_MS=1, CLEAR_MS=2.
module tb_sauto_turn_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    sauto_turn_sequencer_if bus ();

    sauto_turn_sequencer #(
        .CLK_PER_MS(4),
        .TURN_MS   (3),
        .SETTLE_MS (1),
        .CLEAR_MS  (2)
    ) dut (
        .sys_clk(clk),
        .rst    (rst),
        .io     (bus.slave)
    );

    always #5 clk = ~clk;

    // advance one cycle; sample 1 time unit after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {bus.turn_left, bus.turn_right, bus.move_forward,
                bus.busy, bus.finish, bus.blocked, bus.dir_error};
    endfunction

    task automatic clear_inputs();
        bus.start = 1'b0;
        bus.dir_left = 1'b0;
        bus.dir_right = 1'b0;
        bus.abort = 1'b0;
        bus.front_detector = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (outs() !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", outs(), 7'b0);
        end
        rst = 1'b0;
        step();
        checks++;
        if (outs() !== 7'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=%b", outs(), 7'b0);
        end
    endtask

    // start at cycle 0; optional second start pulse during TURN
    task automatic run_left(input string name, input int extra_at);
        logic [4:0] got, exp;
        bus.start = 1'b1;
        bus.dir_left = 1'b1;
        step();
        bus.start = 1'b0;
        bus.dir_left = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            exp = {(k >= 1 && k <= 12), 1'b0, (k >= 17 && k <= 24),
                   (k <= 25), (k == 25)};
            got = {bus.turn_left, bus.turn_right, bus.move_forward,
                   bus.busy, bus.finish};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%b want=%b", name, k, got, exp);
            end
            if (k == extra_at) begin
                bus.start = 1'b1;
                bus.dir_right = 1'b1;
            end else begin
                bus.start = 1'b0;
                bus.dir_right = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_turn_left();
        run_left("turn_left_seq", 0);
    endtask

    task automatic test_back_to_back();
        run_left("second_start", 5);
    endtask

    task automatic test_dir_error();
        for (int m = 0; m < 2; m++) begin
            bus.start = 1'b1;
            bus.dir_left = (m == 0);
            bus.dir_right = (m == 0);
            step();
            clear_inputs();
            checks++;
            if ({bus.dir_error, bus.busy} !== 2'b10) begin
                failures++;
                $display("FAIL dir_error_pulse m=%0d got=%b want=10",
                         m, {bus.dir_error, bus.busy});
            end
            step();
            checks++;
            if ({bus.dir_error, bus.busy} !== 2'b00) begin
                failures++;
                $display("FAIL dir_error_clear m=%0d got=%b want=00",
                         m, {bus.dir_error, bus.busy});
            end
        end
    endtask

    task automatic test_front_block();
        bus.start = 1'b1;
        bus.dir_right = 1'b1;
        step();
        clear_inputs();
        checks++;
        if ({bus.turn_left, bus.turn_right} !== 2'b01) begin
            failures++;
            $display("FAIL right_turn got=%b want=01",
                     {bus.turn_left, bus.turn_right});
        end
        for (int k = 2; k <= 19; k++) step();
        checks++;
        if ({bus.move_forward, bus.busy} !== 2'b11) begin
            failures++;
            $display("FAIL clear_phase got=%b want=11",
                     {bus.move_forward, bus.busy});
        end
        bus.front_detector = 1'b1;
        step();
        bus.front_detector = 1'b0;
        checks++;
        if ({bus.move_forward, bus.finish, bus.busy, bus.blocked} !== 4'b0111) begin
            failures++;
            $display("FAIL front_done got=%b want=0111",
                     {bus.move_forward, bus.finish, bus.busy, bus.blocked});
        end
        step();
        checks++;
        if ({bus.finish, bus.busy, bus.blocked} !== 3'b001) begin
            failures++;
            $display("FAIL blocked_sticky got=%b want=001",
                     {bus.finish, bus.busy, bus.blocked});
        end
        bus.start = 1'b1;
        bus.dir_left = 1'b1;
        step();
        clear_inputs();
        checks++;
        if ({bus.turn_left, bus.blocked} !== 2'b10) begin
            failures++;
            $display("FAIL blocked_clear got=%b want=10",
                     {bus.turn_left, bus.blocked});
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int fin_seen;
        bus.start = 1'b1;
        bus.dir_right = 1'b1;
        step();
        clear_inputs();
        for (int k = 2; k <= 6; k++) step();
        checks++;
        if (bus.turn_right !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got=%b want=1", bus.turn_right);
        end
        bus.abort = 1'b1;
        step();
        checks++;
        if ({bus.turn_right, bus.busy, bus.finish} !== 3'b000) begin
            failures++;
            $display("FAIL abort_stop got=%b want=000",
                     {bus.turn_right, bus.busy, bus.finish});
        end
        bus.start = 1'b1;
        bus.dir_left = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.dir_error, bus.turn_left} !== 3'b000) begin
            failures++;
            $display("FAIL abort_blocks_start got=%b want=000",
                     {bus.busy, bus.dir_error, bus.turn_left});
        end
        clear_inputs();
        fin_seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.finish || bus.busy) fin_seen++;
        end
        checks++;
        if (fin_seen !== 0) begin
            failures++;
            $display("FAIL abort_no_finish got=%0d want=0", fin_seen);
        end
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1;
        bus.dir_left = 1'b1;
        step();
        clear_inputs();
        for (int k = 2; k <= 18; k++) step();
        checks++;
        if (bus.move_forward !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got=%b want=1", bus.move_forward);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.move_forward, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL rst_async got=%b want=00",
                     {bus.move_forward, bus.busy});
        end
        #3 rst = 1'b0;
        step();
        step();
        checks++;
        if (outs() !== 7'b0) begin
            failures++;
            $display("FAIL rst_idle got=%b want=%b", outs(), 7'b0);
        end
    endtask

    initial begin
        test_reset();
        test_turn_left();
        test_dir_error();
        test_front_block();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
